// File: rtl/rsa_uart_wrapper.sv
// rsa_uart_wrapper
// Avalon-MM master that sits between an RS232 UART and the RSA256 core.
// The UART status register is polled before every byte. The wrapper then
// receives the modulus N, the private key D and a stream of ciphertext
// blocks A, each 32 bytes and MSB byte first. Each block goes to the core.
// Each result is returned as 31 bytes, MSB first.
// N and D are kept until the next reset.
//
// Ports
//   i_clk, i_rst           clock, asynchronous active-high reset
//   avm_*                  Avalon-MM master (zero read latency, waitrequest stall)
//   o_core_start           one-cycle start pulse to the core
//   o_core_a/d/n           ciphertext / private key / modulus to the core
//   i_core_result          core result, latched on i_core_finished
//   i_core_finished        core done pulse (only honoured in S_WAIT_CALC)
//
// state        | meaning
// S_IDLE       | post-reset idle, no bus request
// S_QUERY_RX   | read status until an RX byte is available
// S_READ_RX    | read RX byte into N / D / A as selected by phase
// S_START      | pulse o_core_start
// S_WAIT_CALC  | wait for i_core_finished, latch result
// S_QUERY_TX   | read status until TX can accept a byte
// S_WRITE_TX   | write the top result byte to TX
module rsa_uart_wrapper #(
   parameter logic [4:0] RX_BASE     = 5'd0,
   parameter logic [4:0] TX_BASE     = 5'd1,
   parameter logic [4:0] STATUS_BASE = 5'd2,
   parameter int         RX_OK_BIT   = 7,
   parameter int         TX_OK_BIT   = 6,
   parameter int         IN_BYTES    = 32,
   parameter int         OUT_BYTES   = 31
) (
   input  logic         i_clk,
   input  logic         i_rst,
   output logic [4:0]   avm_address,
   output logic         avm_read,
   input  logic [31:0]  avm_readdata,
   output logic         avm_write,
   output logic [31:0]  avm_writedata,
   input  logic         avm_waitrequest,
   output logic         o_core_start,
   output logic [255:0] o_core_a,
   output logic [255:0] o_core_d,
   output logic [255:0] o_core_n,
   input  logic [255:0] i_core_result,
   input  logic         i_core_finished
);

   typedef enum logic [2:0] {
      S_IDLE, S_QUERY_RX, S_READ_RX, S_START, S_WAIT_CALC, S_QUERY_TX, S_WRITE_TX
   } state_t;

   typedef enum logic [1:0] {P_N, P_D, P_A} phase_t;

   localparam logic [4:0] IN_LAST  = 5'(IN_BYTES - 1);
   localparam logic [4:0] OUT_LAST = 5'(OUT_BYTES - 1);

   state_t         state_q, state_d;
   phase_t         phase_q, phase_d;
   logic [4:0]     cnt_q, cnt_d;
   logic [255:0]   n_q, n_d, d_q, d_d, a_q, a_d, res_q, res_d;

   // Only the low data byte and the two status flags are used. The top
   // result byte is always zero because the result is below N < 2^248.
   logic unused_bits;
   assign unused_bits = ^{avm_readdata, res_q[255:248]};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         phase_q <= P_N;
         cnt_q   <= '0;
         n_q     <= '0;
         d_q     <= '0;
         a_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         d_q     <= d_d;
         a_q     <= a_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      cnt_d         = cnt_q;
      n_d           = n_q;
      d_d           = d_q;
      a_d           = a_q;
      res_d         = res_q;
      avm_read      = 1'b0;
      avm_write     = 1'b0;
      avm_address   = '0;
      avm_writedata = '0;
      o_core_start  = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_QUERY_RX;

         S_QUERY_RX: begin
            avm_read    = 1'b1;
            avm_address = STATUS_BASE;
            if (!avm_waitrequest && avm_readdata[RX_OK_BIT])
               state_d = S_READ_RX;
         end

         S_READ_RX: begin
            avm_read    = 1'b1;
            avm_address = RX_BASE;
            if (!avm_waitrequest) begin
               case (phase_q)
                  P_N:     n_d = {n_q[247:0], avm_readdata[7:0]};
                  P_D:     d_d = {d_q[247:0], avm_readdata[7:0]};
                  default: a_d = {a_q[247:0], avm_readdata[7:0]};
               endcase
               state_d = S_QUERY_RX;
               if (cnt_q == IN_LAST) begin
                  cnt_d = '0;
                  case (phase_q)
                     P_N:     phase_d = P_D;
                     P_D:     phase_d = P_A;
                     default: state_d = S_START;
                  endcase
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
            end
         end

         S_START: begin
            o_core_start = 1'b1;
            state_d      = S_WAIT_CALC;
         end

         S_WAIT_CALC: begin
            if (i_core_finished) begin
               res_d   = i_core_result;
               cnt_d   = '0;
               state_d = S_QUERY_TX;
            end
         end

         S_QUERY_TX: begin
            avm_read    = 1'b1;
            avm_address = STATUS_BASE;
            if (!avm_waitrequest && avm_readdata[TX_OK_BIT])
               state_d = S_WRITE_TX;
         end

         S_WRITE_TX: begin
            avm_write     = 1'b1;
            avm_address   = TX_BASE;
            avm_writedata = {24'b0, res_q[247:240]};
            if (!avm_waitrequest) begin
               res_d = {res_q[247:0], 8'h00};
               if (cnt_q == OUT_LAST) begin
                  cnt_d   = '0;
                  state_d = S_QUERY_RX;
               end else begin
                  cnt_d   = cnt_q + 5'd1;
                  state_d = S_QUERY_TX;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign o_core_a = a_q;
   assign o_core_d = d_q;
   assign o_core_n = n_q;

endmodule

// File: tb/tb_rsa_uart_wrapper.sv
// Testbench for rsa_uart_wrapper. A UART slave model and a modular
// exponentiation core model are serviced once per cycle on the falling edge.
module tb_rsa_uart_wrapper;

   logic         clk;
   logic         i_rst;
   logic [4:0]   avm_address;
   logic         avm_read;
   logic [31:0]  avm_readdata;
   logic         avm_write;
   logic [31:0]  avm_writedata;
   logic         avm_waitrequest;
   logic         o_core_start;
   logic [255:0] o_core_a, o_core_d, o_core_n;
   logic [255:0] i_core_result;
   logic         i_core_finished;

   rsa_uart_wrapper dut (
      .i_clk           (clk),
      .i_rst           (i_rst),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_readdata    (avm_readdata),
      .avm_write       (avm_write),
      .avm_writedata   (avm_writedata),
      .avm_waitrequest (avm_waitrequest),
      .o_core_start    (o_core_start),
      .o_core_a        (o_core_a),
      .o_core_d        (o_core_d),
      .o_core_n        (o_core_n),
      .i_core_result   (i_core_result),
      .i_core_finished (i_core_finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // slave / core model state
   logic [7:0]   rxq[$];
   logic [7:0]   txq[$];
   int           rx_hold_cfg = 0, tx_hold_cfg = 0, stall_cfg = 0;
   int           rx_hold = 0, tx_hold = 0, stall_left = 0;
   bit           in_txn = 0, rx_credit = 0, tx_credit = 0;
   logic [4:0]   txn_addr;
   logic         txn_rd, txn_wr;
   logic [31:0]  txn_wd;
   int           rx_consumed = 0, start_cnt = 0;
   bit           core_busy = 0, prev_start = 0, spurious_req = 0;
   int           core_delay = 0;
   logic [255:0] core_res;
   logic [255:0] exp_n, exp_d, exp_a;
   logic [7:0]   last_byte;

   task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [255:0] powmod(input logic [255:0] b, input logic [255:0] e,
                                           input logic [255:0] m);
      longint unsigned r, bb, mm;
      mm = m[63:0];
      bb = b[63:0] % mm;
      r  = 1;
      for (int i = 31; i >= 0; i--) begin
         r = (r * r) % mm;
         if (e[i]) r = (r * bb) % mm;
      end
      return 256'(r);
   endfunction

   task automatic service();
      bit rx_ok, tx_ok;
      logic [7:0] b;
      i_core_finished = 1'b0;
      avm_readdata    = 32'hFFFF_FFFF;
      if (i_rst) begin
         avm_waitrequest = 1'b0;
         in_txn = 0; rx_credit = 0; tx_credit = 0;
         core_busy = 0; prev_start = 0;
         return;
      end
      chk("rd_wr_exclusive", {1'b0, avm_read & avm_write}, 0);

      // core model
      if (o_core_start) begin
         chk("start_single_cycle", {1'b0, prev_start}, 0);
         chk("core_inputs_at_start", {o_core_n, o_core_d, o_core_a}, {exp_n, exp_d, exp_a});
         start_cnt++;
         core_busy  = 1;
         core_delay = 20;
         core_res   = powmod(exp_a, exp_d, exp_n);
      end else if (core_busy) begin
         chk("core_inputs_stable", {o_core_n, o_core_d, o_core_a}, {exp_n, exp_d, exp_a});
         core_delay--;
         if (core_delay == 0) begin
            i_core_finished = 1'b1;
            i_core_result   = core_res;
            core_busy       = 0;
            tx_hold         = tx_hold_cfg;
         end
      end
      prev_start = o_core_start;
      if (spurious_req) begin
         i_core_finished = 1'b1;
         i_core_result   = 256'h55;
         spurious_req    = 0;
      end

      // UART slave
      if (avm_read || avm_write) begin
         if (!in_txn) begin
            in_txn = 1;
            txn_addr = avm_address; txn_rd = avm_read; txn_wr = avm_write; txn_wd = avm_writedata;
            stall_left = stall_cfg;
         end else begin
            chk("bus_hold_stable", {avm_address, avm_read, avm_write, avm_writedata},
                {txn_addr, txn_rd, txn_wr, txn_wd});
         end
         if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
         end else begin
            avm_waitrequest = 1'b0;
            in_txn = 0;
            if (avm_read && avm_address == 5'd2) begin
               rx_ok = (rxq.size() > 0) && (rx_hold == 0);
               tx_ok = (tx_hold == 0);
               if (rxq.size() > 0 && rx_hold > 0) rx_hold--;
               if (tx_hold > 0) tx_hold--;
               avm_readdata = {16'hA5A5, 8'h00, rx_ok, tx_ok, 6'h15};
               rx_credit = rx_ok;
               tx_credit = tx_ok;
            end else if (avm_read && avm_address == 5'd0) begin
               chk("rx_read_after_rx_ok", {1'b0, rx_credit}, 1);
               chk("rx_read_has_data", {1'b0, rxq.size() > 0}, 1);
               b = (rxq.size() > 0) ? rxq.pop_front() : 8'h00;
               avm_readdata = {24'hC3A5E1, b};
               rx_consumed++;
               rx_hold   = rx_hold_cfg;
               rx_credit = 0;
            end else if (avm_write && avm_address == 5'd1) begin
               chk("tx_write_after_tx_ok", {1'b0, tx_credit}, 1);
               chk("tx_upper_zero", {1'b0, avm_writedata[31:8]}, 0);
               txq.push_back(avm_writedata[7:0]);
               tx_credit = 0;
               tx_hold   = tx_hold_cfg;
            end else begin
               chk("bus_legal_access", {avm_read, avm_write, avm_address}, 0);
            end
         end
      end else begin
         avm_waitrequest = 1'b0;
         chk("no_request_drop", {1'b0, in_txn}, 0);
         in_txn = 0;
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      service();
   endtask

   task automatic push_word(input logic [255:0] v);
      for (int i = 31; i >= 0; i--) rxq.push_back(v[8*i +: 8]);
      rx_hold = rx_hold_cfg;
   endtask

   task automatic check_zero(input string name);
      chk(name, {avm_read, avm_write, avm_address, avm_writedata, o_core_start,
                 o_core_a, o_core_d, o_core_n}, 0);
   endtask

   task automatic do_block(input logic [255:0] a);
      logic [255:0] exp_res;
      int s0, n;
      exp_a   = a;
      exp_res = powmod(a, exp_d, exp_n);
      s0 = start_cnt;
      push_word(a);
      n = 0;
      while (txq.size() < 31 && n < 20000) begin
         cyc();
         n++;
      end
      if (txq.size() < 31) chk("tx_timeout", txq.size(), 31);
      repeat (10) cyc();
      chk("tx_count", txq.size(), 31);
      chk("start_count", start_cnt - s0, 1);
      for (int i = 0; i < 31; i++)
         if (i < txq.size())
            chk($sformatf("tx_byte%0d", i), txq[i], exp_res[8*(30-i) +: 8]);
      last_byte = (txq.size() > 0) ? txq[txq.size()-1] : 8'hxx;
      txq.delete();
   endtask

   initial begin
      int base, n, s0;
      i_rst = 1'b1;
      avm_waitrequest = 1'b0;
      avm_readdata = '0;
      i_core_result = '0;
      i_core_finished = 1'b0;
      exp_n = 256'd143;
      exp_d = 256'd7;
      exp_a = '0;

      repeat (3) cyc();
      check_zero("reset_outputs");
      i_rst = 1'b0;
      check_zero("post_reset_outputs");
      cyc();
      chk("first_status_poll", {avm_read, avm_write, avm_address}, {1'b1, 1'b0, 5'd2});

      // load key, first block, no stalls
      push_word(256'd143);
      push_word(256'd7);
      do_block(256'd2);
      chk("t1_result_literal", last_byte, 8'h80);

      // status polling, key reused
      rx_hold_cfg = 5;
      tx_hold_cfg = 3;
      do_block(256'd3);
      chk("t2_result_literal", last_byte, 8'h2A);

      // waitrequest stall on every transaction
      rx_hold_cfg = 0;
      tx_hold_cfg = 0;
      stall_cfg   = 4;
      do_block(256'd5);
      chk("t3_result_literal", last_byte, 8'h2F);

      // spurious finish while polling RX
      stall_cfg = 0;
      s0 = start_cnt;
      spurious_req = 1;
      repeat (60) cyc();
      chk("spurious_no_tx", txq.size(), 0);
      chk("spurious_no_start", start_cnt - s0, 0);

      // fresh reset, then reset in the middle of D
      i_rst = 1'b1;
      cyc();
      i_rst = 1'b0;
      base = rx_consumed;
      push_word(256'd143);
      push_word(256'd7);
      n = 0;
      while (rx_consumed < base + 42 && n < 5000) begin
         cyc();
         n++;
      end
      if (rx_consumed < base + 42) chk("midload_timeout", rx_consumed - base, 42);
      i_rst = 1'b1;
      cyc();
      check_zero("midload_reset_outputs");
      cyc();
      i_rst = 1'b0;
      check_zero("midload_post_reset");
      rxq.delete();
      txq.delete();
      stall_cfg = 1;
      push_word(256'd143);
      push_word(256'd7);
      do_block(256'd4);
      chk("t5_result_literal", last_byte, 8'h52);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rsa_uart_wrapper.md
Name: rsa_uart_wrapper

Overview:
- Avalon-MM master that links the RS232 UART controller to the RSA256 decryption core.
- Polls the UART status register, receives the 32-byte modulus N, the 32-byte private key D, then a stream of 32-byte ciphertext blocks. Each block goes to the core.
- Each decrypted result is returned over the UART as 31 bytes. N and D are loaded once per reset and reused for every block after that.

Parameters:
- RX_BASE, 0, word address of the UART RX data register
- TX_BASE, 1, word address of the UART TX data register
- STATUS_BASE, 2, word address of the UART status register
- RX_OK_BIT, 7, status bit meaning an RX byte is available
- TX_OK_BIT, 6, status bit meaning TX can accept a byte
- IN_BYTES, 32, bytes per N, D and ciphertext word
- OUT_BYTES, 31, bytes returned per result

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- avm_address  out  5  Avalon word address
- avm_read  out  1  Avalon read request
- avm_readdata  in  32  Avalon read data, valid when avm_read=1 and avm_waitrequest=0
- avm_write  out  1  Avalon write request
- avm_writedata  out  32  Avalon write data
- avm_waitrequest  in  1  slave stall
- o_core_start  out  1  one-cycle start pulse to the core
- o_core_a  out  256  ciphertext to the core
- o_core_d  out  256  private key to the core
- o_core_n  out  256  modulus to the core
- i_core_result  in  256  core result
- i_core_finished  in  1  core done pulse

Behaviour:
- Clocking and reset: single clock domain. All registers reset asynchronously on i_rst=1.
- Reset values:
  - state=S_IDLE, phase=P_N, byte counter=0.
  - N, D and A registers = 0; result shift register = 0.
  - All outputs are 0 during and immediately after reset, including avm_address=0.
- Avalon outputs (avm_read, avm_write, avm_address, avm_writedata) are combinational decodes of state and registers.
- Avalon handshake:
  - A transaction completes on a cycle where the request is high and avm_waitrequest=0.
  - While avm_waitrequest=1, state, address, request and writedata hold unchanged.
  - Zero read latency: avm_readdata is sampled on the completing cycle.
- State S_IDLE: no request. Unconditionally goes to S_QUERY_RX next cycle.
- State S_QUERY_RX: avm_read=1, address=STATUS_BASE.
  - On completion with readdata[RX_OK_BIT]=1: go to S_READ_RX.
  - Otherwise stay and reissue the status read on the next cycle.
- State S_READ_RX: avm_read=1, address=RX_BASE. On completion:
  - Shift readdata[7:0] into the target register selected by phase (P_N: N, P_D: D, P_A: A) as reg <= {reg[247:0], byte]}, i.e. MSB byte first.
  - readdata[31:8] is ignored.
  - If counter != IN_BYTES-1: counter++ and return to S_QUERY_RX.
  - If counter == IN_BYTES-1: counter=0. Phase P_N goes to P_D and P_D goes to P_A, both returning to S_QUERY_RX. Phase P_A goes to S_START.
- State S_START: o_core_start=1 for exactly one cycle, then S_WAIT_CALC.
- State S_WAIT_CALC: no bus activity.
  - On i_core_finished=1: latch i_core_result into the result shift register, counter=0, go to S_QUERY_TX.
  - i_core_finished in any other state is ignored.
- State S_QUERY_TX: avm_read=1, address=STATUS_BASE.
  - On completion with readdata[TX_OK_BIT]=1: go to S_WRITE_TX.
  - Otherwise stay and retry.
- State S_WRITE_TX: avm_write=1, address=TX_BASE, writedata={24'b0, result[247:240]}. On completion:
  - Shift the result register left by 8.
  - If counter != OUT_BYTES-1: counter++ and go to S_QUERY_TX.
  - If counter == OUT_BYTES-1: counter=0, phase stays P_A, go to S_QUERY_RX to await the next ciphertext.
  - Result byte 31 (bits [255:248]) is never sent; it is always 0 because the result is less than N, which is less than 2^248.
- Core-facing outputs:
  - o_core_a, o_core_d and o_core_n are driven directly from the registers.
  - They only change in S_READ_RX, so they are stable from o_core_start through i_core_finished.
- Mutual exclusion: avm_read and avm_write are never high in the same cycle.
- Reset mid-operation (any state): returns to S_IDLE with phase P_N. The host must resend N and D.

Test Plan:
- Key load and decrypt, no stalls: send N=0x8F (143, as 32 bytes MSB-first), D=0x07, A=0x02. A behavioural core model returns 2^7 mod 143 = 0x80 -> exactly one o_core_start pulse, o_core_n=143, o_core_d=7, o_core_a=2; TX writes are 30 bytes of 0x00 followed by 0x80.
- Status polling: hold RX_OK=0 for 5 status reads before each byte -> no RX_BASE read until RX_OK=1; byte order and values unchanged. Same check with TX_OK=0 for 3 reads -> no write issued early.
- Waitrequest stall: assert avm_waitrequest for 4 cycles on every transaction -> address, request and writedata held stable throughout; each byte consumed or produced exactly once.
- Second block reuses key: after test 1, send A=0x03 only -> result 3^7 mod 143 = 42 = 0x2A; last TX byte is 0x2A; N and D registers unchanged.
- Spurious finish: pulse i_core_finished while in S_QUERY_RX -> ignored, no TX activity.
- Reset mid-load: assert i_rst after 10 bytes of D -> all outputs 0, phase P_N. A full resend of N, D and A then yields the correct result.
